// File: rtl/ddr_phy_train_pkg.sv
// Shared types and constants for the DDR3 PHY lane read-training sequencer.
package ddr_phy_train_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StSettle,
    StClear,
    StSample,
    StEval,
    StStep,
    StCheck,
    StCenter,
    StDone,
    StFail
  } train_state_e;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_NO_EYE = 2'd1;
  localparam logic [1:0] ERR_NARROW = 2'd2;

  // Width of every strobe sent to the IOD, in FAB_CLK cycles.
  localparam int unsigned PULSE_W = 1;

  localparam int unsigned TMR_W = 8;

endpackage

// File: rtl/lane_train_timer.sv
// Loadable down-counter; tc_o is high once the loaded count has run out.
module lane_train_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/lane_read_training_ctrl.sv
// Per-lane read delay training: sweep taps upward, find the passing eye and park at its centre.
module lane_read_training_ctrl
  import ddr_phy_train_pkg::*;
#(
  parameter int unsigned TAP_W      = 7,
  parameter int unsigned MAX_TAPS   = 128,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned SAMPLE_CYC = 16,
  parameter int unsigned MIN_EYE    = 4
) (
  input  logic             FAB_CLK,
  input  logic             SYNC_RST,
  input  logic             TRAIN_START,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             DELAY_LINE_LOAD,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  output logic             BUSY,
  output logic             TRAIN_DONE,
  output logic             TRAIN_ERR,
  output logic [1:0]       ERR_CODE,
  output logic [TAP_W-1:0] EYE_START,
  output logic [TAP_W-1:0] EYE_END,
  output logic [TAP_W-1:0] TAP_VAL
);

  localparam logic [TAP_W-1:0] LastTap  = TAP_W'(MAX_TAPS - 1);
  localparam logic [TAP_W:0]   MinEye   = (TAP_W + 1)'(MIN_EYE);
  localparam logic [TMR_W-1:0] SettleLd = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] SampleLd = TMR_W'(SAMPLE_CYC - 1);

  train_state_e     state_q;
  logic [TAP_W-1:0] tap_q, eye_start_q, eye_end_q;
  logic [TAP_W:0]   target_q;
  logic             found_q, miss_q, wait_q;
  logic             busy_q, done_q, err_q;
  logic [1:0]       err_code_q;
  logic             move_q, dir_q, load_q, clr_q;

  logic             tmr_load, tmr_tc;
  logic [TMR_W-1:0] tmr_val;
  logic             pass, center_move;
  logic [TAP_W:0]   eye_sum, eye_width;

  assign pass        = ~miss_q;
  assign eye_sum     = {1'b0, eye_start_q} + {1'b0, eye_end_q};
  assign eye_width   = {1'b0, eye_end_q} - {1'b0, eye_start_q} + {{TAP_W{1'b0}}, 1'b1};
  assign center_move = (state_q == StCenter) && !wait_q && ({1'b0, tap_q} > target_q);

  // Every MOVE/LOAD is followed by a settle wait; CLEAR opens the sample window.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = SettleLd;
    if ((state_q == StLoad) || (state_q == StStep) || center_move) begin
      tmr_load = 1'b1;
    end else if (state_q == StClear) begin
      tmr_load = 1'b1;
      tmr_val  = SampleLd;
    end
  end

  lane_train_timer #(
    .Width(TMR_W)
  ) u_timer (
    .clk_i     (FAB_CLK),
    .rst_i     (SYNC_RST),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .tc_o      (tmr_tc)
  );

  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      state_q     <= StIdle;
      tap_q       <= '0;
      eye_start_q <= '0;
      eye_end_q   <= '0;
      target_q    <= '0;
      found_q     <= 1'b0;
      miss_q      <= 1'b0;
      wait_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      move_q      <= 1'b0;
      dir_q       <= 1'b0;
      load_q      <= 1'b0;
      clr_q       <= 1'b0;
    end else begin
      move_q <= 1'b0;
      load_q <= 1'b0;
      clr_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (TRAIN_START) begin
            state_q     <= StLoad;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            found_q     <= 1'b0;
            eye_start_q <= '0;
            eye_end_q   <= '0;
            load_q      <= 1'b1;
          end
        end
        StLoad: begin
          tap_q   <= '0;
          state_q <= StSettle;
        end
        StSettle: begin
          if (tmr_tc) begin
            state_q <= StClear;
            clr_q   <= 1'b1;
          end
        end
        StClear: begin
          miss_q  <= 1'b0;
          state_q <= StSample;
        end
        StSample: begin
          miss_q <= miss_q | EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
          if (tmr_tc) state_q <= StEval;
        end
        StEval: begin
          if (pass) begin
            if (!found_q) eye_start_q <= tap_q;
            found_q   <= 1'b1;
            eye_end_q <= tap_q;
          end
          if ((!pass && found_q) || DELAY_LINE_OUT_OF_RANGE || (tap_q == LastTap)) begin
            state_q <= StCheck;
          end else begin
            state_q <= StStep;
            move_q  <= 1'b1;
            dir_q   <= 1'b1;
          end
        end
        StStep: begin
          tap_q   <= tap_q + 1'b1;
          state_q <= StSettle;
        end
        StCheck: begin
          if (!found_q) begin
            err_code_q <= ERR_NO_EYE;
            state_q    <= StFail;
          end else if (eye_width < MinEye) begin
            err_code_q <= ERR_NARROW;
            state_q    <= StFail;
          end else begin
            target_q <= eye_sum >> 1;
            wait_q   <= 1'b0;
            state_q  <= StCenter;
          end
        end
        StCenter: begin
          if (wait_q) begin
            if (tmr_tc) wait_q <= 1'b0;
          end else if (center_move) begin
            move_q <= 1'b1;
            dir_q  <= 1'b0;
            tap_q  <= tap_q - 1'b1;
            wait_q <= 1'b1;
          end else begin
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        StFail: begin
          err_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign DELAY_LINE_MOVE         = move_q;
  assign DELAY_LINE_DIRECTION    = dir_q;
  assign DELAY_LINE_LOAD         = load_q;
  assign EYE_MONITOR_CLEAR_FLAGS = clr_q;
  assign BUSY                    = busy_q;
  assign TRAIN_DONE              = done_q;
  assign TRAIN_ERR               = err_q;
  assign ERR_CODE                = err_code_q;
  assign EYE_START               = eye_start_q;
  assign EYE_END                 = eye_end_q;
  assign TAP_VAL                 = tap_q;

endmodule

// File: tb/tb_lane_read_training_ctrl.sv
// Self-checking bench: behavioural IOD/eye model plus an arithmetic reference of the sweep result.
module tb_lane_read_training_ctrl;

  localparam int MaxTaps   = 128;
  localparam int SettleCyc = 4;
  localparam int MinEye    = 4;
  localparam int Budget    = 6000;

  logic       clk = 1'b0;
  logic       sync_rst, train_start;
  logic       early = 1'b0, late = 1'b0, oor = 1'b0;
  logic       move, dir, load, clr, busy, done, err;
  logic [1:0] err_code;
  logic [6:0] eye_start, eye_end, tap_val;

  int n_checks = 0, n_fail = 0;
  int win_lo = 1000, win_hi = -1, oor_tap = 127, flag_mode = 0;
  int iod_tap = 0, n_load = 0, n_inc = 0, n_dec = 0, n_viol = 0;
  logic prev_move = 1'b0, prev_load = 1'b0, prev_clr = 1'b0;

  always #5 clk = ~clk;

  lane_read_training_ctrl dut (
    .FAB_CLK                (clk),
    .SYNC_RST               (sync_rst),
    .TRAIN_START            (train_start),
    .EYE_MONITOR_EARLY      (early),
    .EYE_MONITOR_LATE       (late),
    .DELAY_LINE_OUT_OF_RANGE(oor),
    .DELAY_LINE_MOVE        (move),
    .DELAY_LINE_DIRECTION   (dir),
    .DELAY_LINE_LOAD        (load),
    .EYE_MONITOR_CLEAR_FLAGS(clr),
    .BUSY                   (busy),
    .TRAIN_DONE             (done),
    .TRAIN_ERR              (err),
    .ERR_CODE               (err_code),
    .EYE_START              (eye_start),
    .EYE_END                (eye_end),
    .TAP_VAL                (tap_val)
  );

  // IOD model: delay line follows the pulses, sticky flags set on every failing-tap cycle.
  always @(negedge clk) begin
    if ((32'(move) + 32'(load) + 32'(clr)) > 1) n_viol++;
    if ((move && prev_move) || (load && prev_load) || (clr && prev_clr)) n_viol++;
    prev_move = move;
    prev_load = load;
    prev_clr  = clr;
    if (load) begin
      iod_tap = 0;
      n_load++;
    end
    if (move) begin
      if (dir) begin
        iod_tap++;
        n_inc++;
      end else begin
        iod_tap--;
        n_dec++;
      end
    end
    if (clr) begin
      early = 1'b0;
      late  = 1'b0;
    end else if (!(iod_tap >= win_lo && iod_tap <= win_hi)) begin
      if (flag_mode == 1 || $urandom_range(1) == 1) early = 1'b1;
      else late = 1'b1;
    end
    oor = (iod_tap >= oor_tap);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic ref_model(input int lo, input int hi, input int oo, output int stop,
                           output int es, output int ee, output int code, output int tgt);
    bit found, p;
    found = 0; es = 0; ee = 0; stop = 0;
    for (int t = 0; t < MaxTaps; t++) begin
      p    = (t >= lo) && (t <= hi);
      stop = t;
      if (!p && found) break;
      if (p) begin
        if (!found) es = t;
        found = 1;
        ee    = t;
      end
      if (t >= oo || t == MaxTaps - 1) break;
    end
    if (!found) code = 1;
    else if (ee - es + 1 < MinEye) code = 2;
    else code = 0;
    tgt = (code == 0) ? (es + ee) / 2 : stop;
  endtask

  task automatic start_run(input string name, input int lo, input int hi, input int oo,
                           input int fm, output int l0, output int i0, output int d0);
    win_lo = lo; win_hi = hi; oor_tap = oo; flag_mode = fm;
    @(negedge clk);
    l0 = n_load; i0 = n_inc; d0 = n_dec;
    train_start = 1'b1;
    @(negedge clk);
    train_start = 1'b0;
    check({name, "_first_load"}, 64'(load), 64'd1);
    check({name, "_busy_set"}, 64'(busy), 64'd1);
    check({name, "_flags_clr"}, {62'd0, done, err}, 64'd0);
  endtask

  task automatic run_train(input string name, input int lo, input int hi, input int oo,
                           input int fm, input bit poke);
    int l0, i0, d0, stop, es, ee, code, tgt, cyc;
    start_run(name, lo, hi, oo, fm, l0, i0, d0);
    cyc = 0;
    while (busy && cyc < Budget) begin
      @(negedge clk);
      cyc++;
      train_start = (poke && cyc == 40);
    end
    train_start = 1'b0;
    check({name, "_finished"}, 64'(cyc < Budget), 64'd1);
    ref_model(lo, hi, oo, stop, es, ee, code, tgt);
    check({name, "_done"}, 64'(done), 64'(code == 0));
    check({name, "_err"}, 64'(err), 64'(code != 0));
    check({name, "_err_code"}, 64'(err_code), 64'(code));
    check({name, "_eye_start"}, 64'(eye_start), 64'(es));
    check({name, "_eye_end"}, 64'(eye_end), 64'(ee));
    check({name, "_tap_val"}, 64'(tap_val), 64'(tgt));
    check({name, "_iod_tap"}, 64'(iod_tap), 64'(tgt));
    check({name, "_inc_moves"}, 64'(n_inc - i0), 64'(stop));
    check({name, "_dec_moves"}, 64'(n_dec - d0), 64'((code == 0) ? stop - tgt : 0));
    check({name, "_loads"}, 64'(n_load - l0), 64'd1);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {move, dir, load, clr, busy, done, err, err_code, eye_start, eye_end, tap_val},
          '0);
  endtask

  initial begin
    int l0, i0, d0, cyc, lo, hi, oo;
    sync_rst    = 1'b1;
    train_start = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    sync_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_not_busy", 64'(busy), 64'd0);

    run_train("wide_eye", 20, 40, 127, 0, 1'b0);
    run_train("no_eye", 1000, -1, 127, 1, 1'b0);
    run_train("narrow_eye", 50, 52, 127, 0, 1'b0);
    run_train("eye_at_end", 100, 500, 127, 0, 1'b0);
    run_train("tap0_eye", 0, 9, 127, 0, 1'b1);
    run_train("busy_poke", 20, 40, 127, 0, 1'b1);

    // Reset in the middle of the sample window at tap 15, then a clean rerun.
    start_run("mid_reset", 20, 40, 127, 0, l0, i0, d0);
    cyc = 0;
    while (iod_tap != 15 && cyc < Budget) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_reset_reached", 64'(cyc < Budget), 64'd1);
    repeat (SettleCyc + 7) @(negedge clk);
    sync_rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset_outputs");
    sync_rst = 1'b0;
    repeat (2) @(negedge clk);
    run_train("rerun", 20, 40, 127, 0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(3) == 0) begin
        lo = 1000;
        hi = -1;
      end else begin
        lo = int'($urandom_range(0, 120));
        hi = lo + int'($urandom_range(0, 25));
      end
      oo = ($urandom_range(1) == 1) ? 127 : int'($urandom_range(40, 127));
      run_train("random", lo, hi, oo, 0, $urandom_range(1) == 1);
    end

    check("pulse_rules", 64'(n_viol), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
